// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//   Fetch-stage next-PC generator. It sits directly upstream of the 2-bit
//   BHT/BTB direction predictor.
//
//   Each cycle it presents the fetch PC to the predictor. It then uses the
//   predictor's same-cycle taken/offset answer to choose the next PC.
//
//   An in-order record of every fetched instruction's prediction is kept in a
//   small circular FIFO. When execute resolves an instruction, the head record
//   is popped and compared with the actual outcome. A disagreement flushes the
//   pipeline and redirects fetch to the real target.
//
// Ports
//   clk                   in   1      clock, posedge
//   rst                   in   1      synchronous reset, active-high
//   in_fetch_stall        in   1      downstream back-pressure
//   in_pred_taken         in   1      predictor taken for out_fetch_pc
//   in_pred_offset        in   W      predictor PC-relative target offset
//   in_exe_nop            in   1      no instruction resolving this cycle
//   in_exe_is_branch      in   1      resolving instruction is a branch
//   in_exe_pc             in   W      PC of resolving instruction
//   in_exe_branch_taken   in   1      actual direction
//   in_exe_branch_offset  in   W      actual PC-relative offset
//   out_fetch_pc          out  W      current fetch PC (registered)
//   out_fetch_nop         out  1      no valid fetch this cycle
//   out_flush             out  1      squash younger in-flight instructions
//   out_mispredict_cnt    out  CNT_W  saturating mispredict count
//   out_err               out  1      sticky protocol error
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter int INSTR_SIZE_BYTE = 4,
    parameter logic [INSTR_SIZE_BYTE*8-1:0] RESET_PC = '0,
    parameter int PRED_FIFO_DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_fetch_stall,
    input  logic                        in_pred_taken,
    input  logic [INSTR_SIZE_BYTE*8-1:0] in_pred_offset,
    input  logic                        in_exe_nop,
    input  logic                        in_exe_is_branch,
    input  logic [INSTR_SIZE_BYTE*8-1:0] in_exe_pc,
    input  logic                        in_exe_branch_taken,
    input  logic [INSTR_SIZE_BYTE*8-1:0] in_exe_branch_offset,
    output logic [INSTR_SIZE_BYTE*8-1:0] out_fetch_pc,
    output logic                        out_fetch_nop,
    output logic                        out_flush,
    output logic [CNT_W-1:0]            out_mispredict_cnt,
    output logic                        out_err
);
    localparam int W  = INSTR_SIZE_BYTE * 8;
    localparam int AW = $clog2(PRED_FIFO_DEPTH);
    localparam logic [W-1:0]  STEP     = W'(INSTR_SIZE_BYTE);
    localparam logic [AW:0]   OCC_FULL = (AW + 1)'(PRED_FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Prediction record storage (data, never reset)
    logic [W-1:0] rec_pc    [PRED_FIFO_DEPTH];
    logic         rec_taken [PRED_FIFO_DEPTH];
    logic [W-1:0] rec_tgt   [PRED_FIFO_DEPTH];

    logic [W-1:0]  pc_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    logic [CNT_W-1:0] cnt_q;
    logic          err_q;

    logic          fifo_full, fifo_empty;
    logic          resolve, head_valid;
    logic          act_taken;
    logic [W-1:0]  act_tgt, pred_tgt, next_pc;
    logic          mispredict, fire, push, pop;

    // Stage 0: prediction, resolution compare, fire decision
    always_comb begin
        fifo_full  = (occ == OCC_FULL);
        fifo_empty = (occ == '0);
        resolve    = !rst && !in_exe_nop;
        head_valid = resolve && !fifo_empty;
        act_taken  = in_exe_is_branch && in_exe_branch_taken;
        act_tgt    = act_taken ? in_exe_pc + in_exe_branch_offset : in_exe_pc + STEP;
        // Target is only meaningful when both sides say taken; a not-taken
        // pair always falls through to pc+STEP.
        mispredict = head_valid &&
                     ((rec_taken[rd_ptr] != act_taken) ||
                      (act_taken && (rec_tgt[rd_ptr] != act_tgt)));
        fire       = !rst && !in_fetch_stall && !fifo_full && !mispredict;
        push       = fire;
        pop        = head_valid;
        pred_tgt   = pc_q + in_pred_offset;
        next_pc    = in_pred_taken ? pred_tgt : pc_q + STEP;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rec_pc[wr_ptr]    <= pc_q;
            rec_taken[wr_ptr] <= in_pred_taken;
            rec_tgt[wr_ptr]   <= pred_tgt;
        end
    end

    // Stage 1: fetch PC, FIFO control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((resolve && fifo_empty) ||
                (head_valid && (rec_pc[rd_ptr] != in_exe_pc)))
                err_q <= 1'b1;
            if (mispredict) begin
                // Every in-flight record is younger than the mispredicted
                // branch, so the whole FIFO is discarded.
                pc_q   <= act_tgt;
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                cnt_q  <= sat_inc(cnt_q);
            end else begin
                if (fire) pc_q <= next_pc;
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   occ <= occ + OCC_ONE;
                    2'b01:   occ <= occ - OCC_ONE;
                    default: occ <= occ;
                endcase
            end
        end
    end

    assign out_fetch_pc       = pc_q;
    assign out_fetch_nop      = !fire;
    assign out_flush          = mispredict;
    assign out_mispredict_cnt = cnt_q;
    assign out_err            = err_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_fetch_stall;
    logic        in_pred_taken;
    logic [31:0] in_pred_offset;
    logic        in_exe_nop;
    logic        in_exe_is_branch;
    logic [31:0] in_exe_pc;
    logic        in_exe_branch_taken;
    logic [31:0] in_exe_branch_offset;
    logic [31:0] out_fetch_pc;
    logic        out_fetch_nop;
    logic        out_flush;
    logic [15:0] out_mispredict_cnt;
    logic        out_err;

    int vectors = 0;
    int miscompares = 0;

    fetch_pc_gen dut (
        .clk(clk), .rst(rst),
        .in_fetch_stall(in_fetch_stall),
        .in_pred_taken(in_pred_taken), .in_pred_offset(in_pred_offset),
        .in_exe_nop(in_exe_nop), .in_exe_is_branch(in_exe_is_branch),
        .in_exe_pc(in_exe_pc), .in_exe_branch_taken(in_exe_branch_taken),
        .in_exe_branch_offset(in_exe_branch_offset),
        .out_fetch_pc(out_fetch_pc), .out_fetch_nop(out_fetch_nop),
        .out_flush(out_flush), .out_mispredict_cnt(out_mispredict_cnt),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_fetch_stall = 1'b0; in_pred_taken = 1'b0; in_pred_offset = '0;
        in_exe_nop = 1'b1; in_exe_is_branch = 1'b0; in_exe_pc = '0;
        in_exe_branch_taken = 1'b0; in_exe_branch_offset = '0;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (out_fetch_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want %h", out_fetch_pc, 32'h0); end
        vectors++; if (out_fetch_nop !== 1'b1) begin miscompares++; $display("FAIL rst_nop got %b want 1", out_fetch_nop); end
        vectors++; if (out_flush !== 1'b0) begin miscompares++; $display("FAIL rst_flush got %b want 0", out_flush); end
        vectors++; if (out_mispredict_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_cnt got %0d want 0", out_mispredict_cnt); end
        vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", out_err); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (out_fetch_pc !== 32'(i * 4)) begin miscompares++; $display("FAIL seq_pc[%0d] got %h want %h", i, out_fetch_pc, 32'(i * 4)); end
            vectors++; if (out_fetch_nop !== 1'b0) begin miscompares++; $display("FAIL seq_nop[%0d] got %b want 0", i, out_fetch_nop); end
            cycle();
        end
    endtask

    task automatic test_pred_taken_ok();
        logic [31:0] pcs [4];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
        in_pred_taken = 1'b1; in_pred_offset = 32'h40;
        #1;
        vectors++; if (out_fetch_pc !== 32'h10) begin miscompares++; $display("FAIL tk_pc got %h want 10", out_fetch_pc); end
        cycle();
        vectors++; if (out_fetch_pc !== 32'h50) begin miscompares++; $display("FAIL tk_next got %h want 50", out_fetch_pc); end
        in_fetch_stall = 1'b1; in_pred_taken = 1'b0;
        in_exe_nop = 1'b0; in_exe_is_branch = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_exe_pc = pcs[i];
            #1;
            vectors++; if (out_flush !== 1'b0) begin miscompares++; $display("FAIL tk_res_flush[%0d] got %b want 0", i, out_flush); end
            cycle();
        end
        in_exe_pc = 32'h10; in_exe_is_branch = 1'b1; in_exe_branch_taken = 1'b1; in_exe_branch_offset = 32'h40;
        #1;
        vectors++; if (out_flush !== 1'b0) begin miscompares++; $display("FAIL tk_br_flush got %b want 0", out_flush); end
        cycle();
        in_exe_nop = 1'b1;
        #1;
        vectors++; if (out_mispredict_cnt !== 16'd0) begin miscompares++; $display("FAIL tk_cnt got %0d want 0", out_mispredict_cnt); end
        vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL tk_err got %b want 0", out_err); end
        vectors++; if (out_fetch_pc !== 32'h50) begin miscompares++; $display("FAIL tk_hold got %h want 50", out_fetch_pc); end
    endtask

    task automatic test_mispredict();
        in_fetch_stall = 1'b0; in_pred_taken = 1'b1; in_pred_offset = 32'hFFFF_FFD0;
        #1;
        vectors++; if (out_fetch_nop !== 1'b0) begin miscompares++; $display("FAIL mp_nop0 got %b want 0", out_fetch_nop); end
        cycle();
        in_pred_taken = 1'b0;
        #1;
        vectors++; if (out_fetch_pc !== 32'h20) begin miscompares++; $display("FAIL mp_pc20 got %h want 20", out_fetch_pc); end
        cycle();
        in_fetch_stall = 1'b1;
        in_exe_nop = 1'b0; in_exe_pc = 32'h50; in_exe_is_branch = 1'b1;
        in_exe_branch_taken = 1'b1; in_exe_branch_offset = 32'hFFFF_FFD0;
        #1;
        vectors++; if (out_flush !== 1'b0) begin miscompares++; $display("FAIL mp_first_flush got %b want 0", out_flush); end
        cycle();
        in_exe_pc = 32'h20; in_exe_branch_offset = 32'hFFFF_FFF8; in_fetch_stall = 1'b0;
        #1;
        vectors++; if (out_flush !== 1'b1) begin miscompares++; $display("FAIL mp_flush got %b want 1", out_flush); end
        vectors++; if (out_fetch_nop !== 1'b1) begin miscompares++; $display("FAIL mp_nop got %b want 1", out_fetch_nop); end
        cycle();
        in_exe_nop = 1'b1; in_fetch_stall = 1'b1;
        #1;
        vectors++; if (out_flush !== 1'b0) begin miscompares++; $display("FAIL mp_flush_off got %b want 0", out_flush); end
        vectors++; if (out_fetch_pc !== 32'h18) begin miscompares++; $display("FAIL mp_redirect got %h want 18", out_fetch_pc); end
        vectors++; if (out_mispredict_cnt !== 16'd1) begin miscompares++; $display("FAIL mp_cnt got %0d want 1", out_mispredict_cnt); end
        vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL mp_err got %b want 0", out_err); end
    endtask

    task automatic test_fifo_full();
        in_fetch_stall = 1'b0; in_pred_taken = 1'b0; in_exe_nop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (out_fetch_nop !== 1'b0) begin miscompares++; $display("FAIL full_fill_nop[%0d] got %b want 0", i, out_fetch_nop); end
            cycle();
        end
        #1;
        vectors++; if (out_fetch_nop !== 1'b1) begin miscompares++; $display("FAIL full_nop got %b want 1", out_fetch_nop); end
        vectors++; if (out_fetch_pc !== 32'h38) begin miscompares++; $display("FAIL full_pc got %h want 38", out_fetch_pc); end
        cycle();
        vectors++; if (out_fetch_pc !== 32'h38) begin miscompares++; $display("FAIL full_hold got %h want 38", out_fetch_pc); end
        in_exe_nop = 1'b0; in_exe_pc = 32'h18; in_exe_is_branch = 1'b0;
        #1;
        vectors++; if (out_fetch_nop !== 1'b1) begin miscompares++; $display("FAIL full_popcyc_nop got %b want 1", out_fetch_nop); end
        cycle();
        in_exe_nop = 1'b1;
        #1;
        vectors++; if (out_fetch_nop !== 1'b0) begin miscompares++; $display("FAIL full_freed_nop got %b want 0", out_fetch_nop); end
        cycle();
        vectors++; if (out_fetch_pc !== 32'h3C) begin miscompares++; $display("FAIL full_adv got %h want 3c", out_fetch_pc); end
        vectors++; if (out_fetch_nop !== 1'b1) begin miscompares++; $display("FAIL full_again_nop got %b want 1", out_fetch_nop); end
        vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL full_err got %b want 0", out_err); end
    endtask

    task automatic test_err();
        do_reset();
        vectors++; if (out_mispredict_cnt !== 16'd0) begin miscompares++; $display("FAIL err_rst_cnt got %0d want 0", out_mispredict_cnt); end
        rst = 1'b0; in_fetch_stall = 1'b1;
        in_exe_nop = 1'b0; in_exe_pc = 32'h0;
        #1;
        vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL err_pre got %b want 0", out_err); end
        cycle();
        in_exe_nop = 1'b1;
        vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL err_empty got %b want 1", out_err); end
        cycle();
        vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", out_err); end
        do_reset();
        rst = 1'b0;
        cycle();
        in_fetch_stall = 1'b1;
        vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL err_clr got %b want 0", out_err); end
        in_exe_nop = 1'b0; in_exe_pc = 32'h100; in_exe_is_branch = 1'b0;
        #1;
        vectors++; if (out_flush !== 1'b0) begin miscompares++; $display("FAIL err_pc_flush got %b want 0", out_flush); end
        cycle();
        in_exe_nop = 1'b1;
        vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL err_pc got %b want 1", out_err); end
    endtask

    task automatic test_wrap_and_midreset();
        do_reset();
        rst = 1'b0; in_pred_taken = 1'b1; in_pred_offset = 32'hFFFF_FFFC;
        cycle();
        in_pred_taken = 1'b0;
        vectors++; if (out_fetch_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc got %h want fffffffc", out_fetch_pc); end
        cycle();
        vectors++; if (out_fetch_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_next got %h want 0", out_fetch_pc); end
        cycle();
        vectors++; if (out_fetch_pc !== 32'h4) begin miscompares++; $display("FAIL wrap_4 got %h want 4", out_fetch_pc); end
        rst = 1'b1;
        cycle();
        #1;
        vectors++; if (out_fetch_pc !== 32'h0) begin miscompares++; $display("FAIL mrst_pc got %h want 0", out_fetch_pc); end
        vectors++; if (out_fetch_nop !== 1'b1) begin miscompares++; $display("FAIL mrst_nop got %b want 1", out_fetch_nop); end
        vectors++; if (out_mispredict_cnt !== 16'd0) begin miscompares++; $display("FAIL mrst_cnt got %0d want 0", out_mispredict_cnt); end
        // If any record survived, head pc 0 would match and err would stay 0.
        rst = 1'b0; in_fetch_stall = 1'b1; in_exe_nop = 1'b0; in_exe_pc = 32'h0;
        cycle();
        in_exe_nop = 1'b1;
        vectors++; if (out_err !== 1'b1) begin miscompares++; $display("FAIL mrst_empty got %b want 1", out_err); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_pred_taken_ok();
        test_mispredict();
        test_fifo_full();
        test_err();
        test_wrap_and_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
